// File: rtl/seg_pkg.sv
// Shared 7-segment decode table, segment bit indices and per-slot scan states.
// SEG bit order is a..g on bits 0..6.
package seg_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } scan_state_t;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Purpose: per-digit slot timer, BLANK_CYCLES blanked then PRESCALE-BLANK_CYCLES lit.
// Latency: on_start/slot_end are combinational strobes in the cycle before the state changes.
// Backpressure: none, free-running once out of reset.
module seg_scan_timer #(
    parameter int PRESCALE     = 12000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic core_clk,
    input  logic srst_n,
    output logic slot_end,
    output logic on_start
);
    import seg_pkg::*;

    localparam int CNT_W = $clog2(PRESCALE);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    scan_state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge core_clk) begin
        if (!srst_n) begin
            state <= BLANK;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        slot_end  = 1'b0;
        on_start  = 1'b0;
        case (state)
            BLANK: begin
                if (cnt == BLANK_LAST) begin
                    on_start  = 1'b1;
                    state_nxt = ON;
                end
            end
            ON: begin
                if (cnt == CNT_LAST) begin
                    slot_end  = 1'b1;
                    state_nxt = BLANK;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = BLANK;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Purpose: double-buffered, blank-gapped scan driver for a multiplexed 7-segment display; LEADING_ZERO_BLANK_EN blanks leading zero digits.
// Latency: registered outputs; a load is displayed from the next frame start (at most NUM_DIGITS*PRESCALE+BLANK_CYCLES cycles).
// Backpressure: none, load is always accepted and the newest value wins.
module seg_scan_driver #(
    parameter int NUM_DIGITS    = 2,
    parameter int PRESCALE      = 12000,
    parameter int BLANK_CYCLES  = 16,
    parameter int SEG_ACT_LOW   = 0,
    parameter int DIGIT_ACT_LOW = 0
) (
    input  logic                    CLK,
    input  logic                    RESETN,
    input  logic [4*NUM_DIGITS-1:0] hex_in,
    input  logic                    load,
    output logic [6:0]              SEG,
    output logic [NUM_DIGITS-1:0]   DIGIT,
    output logic                    frame_tick
);
    import seg_pkg::*;

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_INV   = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] DIGIT_INV = (DIGIT_ACT_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                       : {NUM_DIGITS{1'b0}};

    logic                    slot_end;
    logic                    on_start;
    logic                    wrap;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [4*NUM_DIGITS-1:0] pending;
    logic                    pend_flag;
    logic [3:0]              cur_nib;
    logic                    lz_blank;
    logic [6:0]              seg_on;
    logic [NUM_DIGITS-1:0]   digit_on;

    seg_scan_timer #(
        .PRESCALE    (PRESCALE),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_timer (
        .core_clk(CLK),
        .srst_n  (RESETN),
        .slot_end(slot_end),
        .on_start(on_start)
    );

    // Last ON cycle of the last digit: the only point where shadow may change.
    assign wrap = slot_end && (idx == IDX_LAST);

    always_comb begin
        cur_nib     = shadow[4*idx +: 4];
        digit_on    = '0;
        digit_on[idx] = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        lz_blank    = (idx != '0) && ((shadow >> (4*idx)) == '0);
`else
        lz_blank    = 1'b0;
`endif
        seg_on      = lz_blank ? 7'h00 : hex_to_seg(cur_nib);
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            idx        <= '0;
            shadow     <= '0;
            pending    <= '0;
            pend_flag  <= 1'b0;
            frame_tick <= 1'b0;
            SEG        <= SEG_INV;
            DIGIT      <= DIGIT_INV;
        end else begin
            frame_tick <= wrap;

            if (slot_end) begin
                idx <= wrap ? '0 : idx + 1'b1;
            end

            if (load) begin
                pending <= hex_in;
            end

            // A load landing on the wrap bypasses pending so the newest value is shown at once.
            if (wrap && load) begin
                shadow    <= hex_in;
                pend_flag <= 1'b0;
            end else if (wrap && pend_flag) begin
                shadow    <= pending;
                pend_flag <= 1'b0;
            end else if (load) begin
                pend_flag <= 1'b1;
            end

            if (on_start) begin
                SEG   <= seg_on ^ SEG_INV;
                DIGIT <= digit_on ^ DIGIT_INV;
            end else if (slot_end) begin
                SEG   <= SEG_INV;
                DIGIT <= DIGIT_INV;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver with NUM_DIGITS=2, PRESCALE=8, BLANK_CYCLES=2; second instance is active-low.
// k counts rising edges since reset release; outputs are sampled on the falling edge.
module tb_seg_scan_driver;

    typedef struct packed {
        logic [1:0] dig;
        logic [6:0] seg;
    } slot_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] hex_in = 8'h00;
    logic [7:0] hex_in2 = 8'h00;
    logic       load = 1'b0;
    logic       load2 = 1'b0;
    logic [6:0] seg, seg2;
    logic [1:0] digit, digit2;
    logic       ft, ft2;

    slot_t      exp_q[$];
    slot_t      exp_s;
    logic [1:0] prev_dig;
    int         checks = 0;
    int         failures = 0;
    int         k = 0;

    seg_scan_driver #(
        .NUM_DIGITS(2), .PRESCALE(8), .BLANK_CYCLES(2), .SEG_ACT_LOW(0), .DIGIT_ACT_LOW(0)
    ) dut (
        .CLK(clk), .RESETN(rstn), .hex_in(hex_in), .load(load),
        .SEG(seg), .DIGIT(digit), .frame_tick(ft)
    );

    seg_scan_driver #(
        .NUM_DIGITS(2), .PRESCALE(8), .BLANK_CYCLES(2), .SEG_ACT_LOW(1), .DIGIT_ACT_LOW(1)
    ) dut_al (
        .CLK(clk), .RESETN(rstn), .hex_in(hex_in2), .load(load2),
        .SEG(seg2), .DIGIT(digit2), .frame_tick(ft2)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
        k++;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) step();
        checks++; if (seg !== 7'h00) begin failures++; $display("FAIL reset_seg got=%h exp=00", seg); end
        checks++; if (digit !== 2'b00) begin failures++; $display("FAIL reset_digit got=%b exp=00", digit); end
        checks++; if (ft !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", ft); end
        rstn = 1'b1;
        k = 0;
        step();
        checks++; if (digit !== 2'b00) begin failures++; $display("FAIL release_k1_digit got=%b exp=00", digit); end
        step();
        checks++; if (digit !== 2'b01) begin failures++; $display("FAIL release_k2_digit got=%b exp=01", digit); end
        checks++; if (seg !== 7'h3F) begin failures++; $display("FAIL release_k2_seg got=%h exp=3F", seg); end
    endtask

    task automatic test_scan_timing();
        int         cnt;
        logic [1:0] exp_dig;
        hex_in = 8'h4A; load = 1'b1;
        step();
        load = 1'b0;
        while (k < 15) step();
        for (int f = 0; f < 2; f++) begin
            exp_q.push_back({2'b01, 7'h77});
            exp_q.push_back({2'b10, 7'h66});
        end
        prev_dig = digit;
        while (k < 47) begin
            step();
            cnt     = k % 8;
            exp_dig = (cnt < 2) ? 2'b00 : (((k / 8) % 2) != 0 ? 2'b10 : 2'b01);
            checks++; if (digit !== exp_dig) begin failures++; $display("FAIL scan_digit k=%0d got=%b exp=%b", k, digit, exp_dig); end
            checks++; if (ft !== (k % 16 == 0)) begin failures++; $display("FAIL scan_tick k=%0d got=%b exp=%b", k, ft, (k % 16 == 0)); end
            if (cnt < 2) begin
                checks++; if (seg !== 7'h00) begin failures++; $display("FAIL scan_blank_seg k=%0d got=%h exp=00", k, seg); end
            end
            if (digit != 2'b00 && prev_dig == 2'b00) begin
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL scan_slot k=%0d got=%b/%h exp=none", k, digit, seg); end
                else begin
                    exp_s = exp_q.pop_front();
                    if ({digit, seg} !== exp_s) begin failures++; $display("FAIL scan_slot k=%0d got=%b/%h exp=%b/%h", k, digit, seg, exp_s.dig, exp_s.seg); end
                end
            end
            prev_dig = digit;
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scan_left got=%0d exp=0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_no_tearing();
        while (k < 59) step();
        hex_in = 8'h12; load = 1'b1;
        step();
        load = 1'b0;
        exp_q.push_back({2'b01, 7'h5B});
        exp_q.push_back({2'b10, 7'h06});
        prev_dig = digit;
        while (k < 79) begin
            if (k <= 63) begin
                checks++; if ({digit, seg} !== {2'b10, 7'h66}) begin failures++; $display("FAIL tear_hold k=%0d got=%b/%h exp=10/66", k, digit, seg); end
            end
            step();
            if (k == 64) begin
                checks++; if (ft !== 1'b1) begin failures++; $display("FAIL tear_tick got=%b exp=1", ft); end
            end
            if (digit != 2'b00 && prev_dig == 2'b00) begin
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL tear_slot k=%0d got=%b/%h exp=none", k, digit, seg); end
                else begin
                    exp_s = exp_q.pop_front();
                    if ({digit, seg} !== exp_s) begin failures++; $display("FAIL tear_slot k=%0d got=%b/%h exp=%b/%h", k, digit, seg, exp_s.dig, exp_s.seg); end
                end
            end
            prev_dig = digit;
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL tear_left got=%0d exp=0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_collisions();
        hex_in = 8'h37; load = 1'b1;
        step();
        load = 1'b0;
        checks++; if (ft !== 1'b1) begin failures++; $display("FAIL wrap_tick got=%b exp=1", ft); end
        exp_q.push_back({2'b01, 7'h07});
        exp_q.push_back({2'b10, 7'h4F});
        exp_q.push_back({2'b01, 7'h07});
        exp_q.push_back({2'b10, 7'h4F});
        exp_q.push_back({2'b01, 7'h5B});
        exp_q.push_back({2'b10, 7'h5B});
        prev_dig = digit;
        while (k < 127) begin
            if (k == 97) begin hex_in = 8'h11; load = 1'b1; end
            else if (k == 103) begin hex_in = 8'h22; load = 1'b1; end
            else load = 1'b0;
            step();
            if (digit != 2'b00 && prev_dig == 2'b00) begin
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL coll_slot k=%0d got=%b/%h exp=none", k, digit, seg); end
                else begin
                    exp_s = exp_q.pop_front();
                    if ({digit, seg} !== exp_s) begin failures++; $display("FAIL coll_slot k=%0d got=%b/%h exp=%b/%h", k, digit, seg, exp_s.dig, exp_s.seg); end
                end
            end
            prev_dig = digit;
        end
        load = 1'b0;
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL coll_left got=%0d exp=0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_leading_zero();
        logic [6:0] lz_seg;
`ifdef LEADING_ZERO_BLANK_EN
        lz_seg = 7'h00;
`else
        lz_seg = 7'h3F;
`endif
        hex_in = 8'h05; load = 1'b1;
        step();
        load = 1'b0;
        exp_q.push_back({2'b01, 7'h6D});
        exp_q.push_back({2'b10, lz_seg});
        exp_q.push_back({2'b01, 7'h3F});
        exp_q.push_back({2'b10, lz_seg});
        prev_dig = digit;
        while (k < 159) begin
            if (k == 143) begin hex_in = 8'h00; load = 1'b1; end
            else load = 1'b0;
            step();
            if (digit != 2'b00 && prev_dig == 2'b00) begin
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL lz_slot k=%0d got=%b/%h exp=none", k, digit, seg); end
                else begin
                    exp_s = exp_q.pop_front();
                    if ({digit, seg} !== exp_s) begin failures++; $display("FAIL lz_slot k=%0d got=%b/%h exp=%b/%h", k, digit, seg, exp_s.dig, exp_s.seg); end
                end
            end
            prev_dig = digit;
        end
        load = 1'b0;
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL lz_left got=%0d exp=0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_polarity();
        step();
        hex_in = 8'h99; load = 1'b1;
        step();
        load = 1'b0;
        while (k < 164) step();
        rstn = 1'b0;
        step();
        checks++; if ({digit, seg, ft} !== {2'b00, 7'h00, 1'b0}) begin failures++; $display("FAIL midreset_hi got=%b/%h/%b exp=00/00/0", digit, seg, ft); end
        checks++; if ({digit2, seg2, ft2} !== {2'b11, 7'h7F, 1'b0}) begin failures++; $display("FAIL midreset_lo got=%b/%h/%b exp=11/7F/0", digit2, seg2, ft2); end
        rstn = 1'b1;
        k = 0;
        hex_in2 = 8'h0F; load2 = 1'b1;
        step();
        load2 = 1'b0;
        step();
        checks++; if ({digit2, seg2} !== {2'b10, 7'h40}) begin failures++; $display("FAIL pol_first got=%b/%h exp=10/40", digit2, seg2); end
        exp_q.push_back({2'b10, 7'h0E});
        exp_q.push_back({2'b01, 7'h3F});
        while (k < 18) step();
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL pol_slot got=%b/%h exp=none", digit2, seg2); end
        else begin
            exp_s = exp_q.pop_front();
            if ({digit2, seg2} !== exp_s) begin failures++; $display("FAIL pol_slot got=%b/%h exp=%b/%h", digit2, seg2, exp_s.dig, exp_s.seg); end
        end
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL pending_lost got=%b/%h exp=none", digit, seg); end
        else begin
            exp_s = exp_q.pop_front();
            if ({digit, seg} !== exp_s) begin failures++; $display("FAIL pending_lost got=%b/%h exp=%b/%h", digit, seg, exp_s.dig, exp_s.seg); end
        end
    endtask

    initial begin
        test_reset();
        test_scan_timing();
        test_no_tearing();
        test_collisions();
        test_leading_zero();
        test_polarity();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
